// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-fetch memory responder.
package cpu_pkg;

  localparam int INSN_W = 32;

  // Value returned on read_data before the first response.
  localparam logic [INSN_W-1:0] NOP = 32'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/insn_line_buf.sv
// Single instruction line buffer: LINE_WORDS words, one tag, one valid bit.
// Combinational read and hit compare; words are written one at a time during refill.
module insn_line_buf
  import cpu_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                                    clk,
  input  logic                                    srst,
  input  logic                                    wr_en,
  input  logic [$clog2(LINE_WORDS)-1:0]           wr_idx,
  input  logic [INSN_W-1:0]                       wr_data,
  input  logic                                    tag_load,
  input  logic [ADDR_W-$clog2(LINE_WORDS)-3:0]    tag_in,
  input  logic                                    valid_set,
  input  logic                                    valid_clr,
  input  logic [$clog2(LINE_WORDS)-1:0]           rd_idx,
  input  logic [ADDR_W-$clog2(LINE_WORDS)-3:0]    lookup_tag,
  output logic [INSN_W-1:0]                       rd_word,
  output logic                                    hit
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [INSN_W-1:0] word_vec [LINE_WORDS];
  logic [TAG_W-1:0]  tag_reg;
  logic              valid_reg;

  for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_word
    logic [INSN_W-1:0] word_reg;

    // Capture refill data when this word slot is addressed.
    always_ff @(posedge clk) begin
      if (wr_en && (wr_idx == IDX_W'(gi))) begin
        word_reg <= wr_data;
      end
    end

    assign word_vec[gi] = word_reg;
  end

  // Valid flag; a clear in the same cycle as a set wins.
  always_ff @(posedge clk) begin
    if (srst) begin
      valid_reg <= 1'b0;
    end else if (valid_clr) begin
      valid_reg <= 1'b0;
    end else if (valid_set) begin
      valid_reg <= 1'b1;
    end
  end

  // Tag of the line currently held, loaded when a refill completes.
  always_ff @(posedge clk) begin
    if (srst) begin
      tag_reg <= '0;
    end else if (tag_load) begin
      tag_reg <= tag_in;
    end
  end

  assign rd_word = word_vec[rd_idx];
  assign hit     = valid_reg && (tag_reg == lookup_tag);

endmodule

// File: rtl/insn_mem_responder.sv
// Fetch-side responder: hits answered next cycle, misses refill the whole line
// word by word over the backing req/ack bus, then respond from the buffer.
module insn_mem_responder
  import cpu_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              read_flag,
  input  logic [ADDR_W-1:0] addr,
  output logic [INSN_W-1:0] read_data,
  output logic              busy,
  output logic              done,
  input  logic              inv,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [INSN_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int OFF_W = IDX_W + 2;
  localparam int TAG_W = ADDR_W - OFF_W;

  // Byte-lane bits of the request address play no part in lookup.
  logic addr_unused;
  assign addr_unused = ^addr[1:0];

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [ADDR_W-1:0] line_base;

  assign req_tag   = addr[ADDR_W-1:OFF_W];
  assign req_idx   = addr[OFF_W-1:2];
  assign line_base = {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  state_t            state_reg, state_next;
  logic [TAG_W-1:0]  tag_reg, tag_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [IDX_W-1:0]  cnt_reg, cnt_next;
  logic              inv_seen_reg, inv_seen_next;
  logic [INSN_W-1:0] read_data_reg, read_data_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              mem_req_reg, mem_req_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;

  logic              buf_wr_en;
  logic              buf_tag_load;
  logic              buf_valid_set;
  logic              buf_valid_clr;
  logic [IDX_W-1:0]  buf_rd_idx;
  logic [INSN_W-1:0] buf_rd_word;
  logic              buf_hit;

  insn_line_buf #(
    .LINE_WORDS (LINE_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_line_buf (
    .clk        (CLK),
    .srst       (RST),
    .wr_en      (buf_wr_en),
    .wr_idx     (cnt_reg),
    .wr_data    (mem_rdata),
    .tag_load   (buf_tag_load),
    .tag_in     (tag_reg),
    .valid_set  (buf_valid_set),
    .valid_clr  (buf_valid_clr),
    .rd_idx     (buf_rd_idx),
    .lookup_tag (req_tag),
    .rd_word    (buf_rd_word),
    .hit        (buf_hit)
  );

  // State, latched request and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= IDLE;
      tag_reg       <= '0;
      idx_reg       <= '0;
      cnt_reg       <= '0;
      inv_seen_reg  <= 1'b0;
      read_data_reg <= NOP;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      mem_req_reg   <= 1'b0;
      mem_addr_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      tag_reg       <= tag_next;
      idx_reg       <= idx_next;
      cnt_reg       <= cnt_next;
      inv_seen_reg  <= inv_seen_next;
      read_data_reg <= read_data_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      mem_req_reg   <= mem_req_next;
      mem_addr_reg  <= mem_addr_next;
    end
  end

  // Next-state, refill handshake and line-buffer control.
  always_comb begin
    state_next     = state_reg;
    tag_next       = tag_reg;
    idx_next       = idx_reg;
    cnt_next       = cnt_reg;
    inv_seen_next  = inv_seen_reg;
    read_data_next = read_data_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    mem_req_next   = mem_req_reg;
    mem_addr_next  = mem_addr_reg;
    buf_wr_en      = 1'b0;
    buf_tag_load   = 1'b0;
    buf_valid_set  = 1'b0;
    buf_valid_clr  = inv;
    buf_rd_idx     = (state_reg == RESP) ? idx_reg : req_idx;

    case (state_reg)
      IDLE: begin
        if (read_flag) begin
          if (buf_hit && !inv) begin
            read_data_next = buf_rd_word;
            done_next      = 1'b1;
          end else begin
            // Miss (or invalidated this cycle): start a full-line refill.
            state_next    = FILL;
            tag_next      = req_tag;
            idx_next      = req_idx;
            cnt_next      = '0;
            inv_seen_next = 1'b0;
            busy_next     = 1'b1;
            mem_req_next  = 1'b1;
            mem_addr_next = line_base;
            buf_valid_clr = 1'b1;
          end
        end
      end

      FILL: begin
        if (inv) begin
          inv_seen_next = 1'b1;
        end
        if (mem_ack) begin
          buf_wr_en = 1'b1;
          if (cnt_reg == IDX_W'(LINE_WORDS - 1)) begin
            // Last word: an invalidate seen during the refill keeps the line invalid.
            buf_tag_load  = 1'b1;
            buf_valid_set = !(inv_seen_reg || inv);
            mem_req_next  = 1'b0;
            state_next    = RESP;
          end else begin
            cnt_next      = cnt_reg + IDX_W'(1);
            mem_addr_next = mem_addr_reg + ADDR_W'(4);
          end
        end
      end

      RESP: begin
        read_data_next = buf_rd_word;
        busy_next      = 1'b0;
        done_next      = 1'b1;
        state_next     = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign read_data = read_data_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign mem_req   = mem_req_reg;
  assign mem_addr  = mem_addr_reg;

endmodule

// File: tb/tb_insn_mem_responder.sv
// Directed bench for insn_mem_responder with a latency-programmable backing memory.
module tb_insn_mem_responder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        read_flag = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] read_data;
  logic        busy;
  logic        done;
  logic        inv = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;

  int          n_checks = 0;
  int          n_fail = 0;
  int          mem_lat = 3;
  int          ack_total = 0;
  logic [31:0] ack_addr [64];
  int          stray_cnt = 0;
  int          stray_seen = 0;

  insn_mem_responder #(.LINE_WORDS(4), .ADDR_W(32)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .read_flag (read_flag),
    .addr      (addr),
    .read_data (read_data),
    .busy      (busy),
    .done      (done),
    .inv       (inv),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 CLK = ~CLK;

  // Backing memory contents: a recognisable tag plus the low address half.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE0000 | {16'h0, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Backing memory: acks each request after mem_lat cycles of mem_req high.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge CLK);
      if (mem_ack) begin
        mem_ack = 1'b0;
        cnt = 0;
      end
      if (stray_seen != stray_cnt) begin
        stray_seen++;
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
      end else if (mem_req) begin
        cnt++;
        if (cnt >= mem_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_word(mem_addr);
          ack_addr[ack_total % 64] = mem_addr;
          ack_total++;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // One fetch. exp_base is the hand-computed line base for a miss.
  task automatic do_read(input logic [31:0] a, input bit miss, input logic [31:0] exp_base,
                         input logic [31:0] exp, input bit with_inv, input int inv_at,
                         input bit poke);
    int base_acks;
    int k;
    @(negedge CLK);
    read_flag = 1'b1;
    addr      = a;
    inv       = with_inv;
    base_acks = ack_total;
    @(negedge CLK);
    read_flag = 1'b0;
    inv       = 1'b0;
    addr      = 32'h0000_0FF4;
    if (!miss) begin
      check("hit_done", done, 1);
      check("hit_busy", busy, 0);
      check("hit_mem_req", mem_req, 0);
      check("hit_data", read_data, exp);
    end else begin
      check("miss_busy", busy, 1);
      check("miss_done", done, 0);
      check("miss_mem_req", mem_req, 1);
      check("miss_mem_addr", mem_addr, exp_base);
      k = 0;
      while (!done && k < 200) begin
        if (k == inv_at) inv = 1'b1;
        if (poke && k == 1) begin
          read_flag = 1'b1;
          addr      = 32'h0000_0040;
        end
        @(negedge CLK);
        inv       = 1'b0;
        read_flag = 1'b0;
        k++;
      end
      check("miss_resp_done", done, 1);
      check("miss_resp_busy", busy, 0);
      check("miss_resp_data", read_data, exp);
      check("miss_ack_count", ack_total - base_acks, 4);
      for (int i = 0; i < 4; i++) begin
        check("miss_fill_addr", ack_addr[(base_acks + i) % 64], exp_base + 32'(4 * i));
      end
    end
    $display("read addr=%h miss=%0d data=%h", a, miss, read_data);
    @(negedge CLK);
    check("done_single", done, 0);
    check("idle_mem_req", mem_req, 0);
  endtask

  initial begin
    int base;
    int k;

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_read_data", read_data, 32'h0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 32'h0);
    RST = 1'b0;

    // Cold miss at 0x0, word latency 3
    mem_lat = 3;
    do_read(32'h0, 1, 32'h0, 32'hC0DE0000, 0, -1, 0);

    // Sequential hits in the same line
    do_read(32'h4, 0, 32'h0, 32'hC0DE0004, 0, -1, 0);
    do_read(32'h8, 0, 32'h0, 32'hC0DE0008, 0, -1, 0);
    do_read(32'hC, 0, 32'h0, 32'hC0DE000C, 0, -1, 0);

    // Idle: outputs hold
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("idle_data", read_data, 32'hC0DE000C);
      check("idle_done", done, 0);
    end

    // Jump away and back: two refills, the second with an ignored request while busy
    mem_lat = 1;
    do_read(32'h100, 1, 32'h100, 32'hC0DE0100, 0, -1, 0);
    do_read(32'h0, 1, 32'h0, 32'hC0DE0000, 0, -1, 1);

    // Invalidate together with a request on a valid line: served as a miss
    do_read(32'h8, 1, 32'h0, 32'hC0DE0008, 1, -1, 0);
    do_read(32'hC, 0, 32'h0, 32'hC0DE000C, 0, -1, 0);

    // Invalidate during refill: delivered, but the line stays invalid
    mem_lat = 2;
    do_read(32'h200, 1, 32'h200, 32'hC0DE0200, 0, 2, 0);
    do_read(32'h204, 1, 32'h200, 32'hC0DE0204, 0, -1, 0);

    // Top-of-memory line
    do_read(32'hFFFF_FFFC, 1, 32'hFFFF_FFF0, 32'hC0DEFFFC, 0, -1, 0);

    // Reset in the middle of a refill
    mem_lat = 3;
    @(negedge CLK);
    read_flag = 1'b1;
    addr      = 32'h300;
    base      = ack_total;
    @(negedge CLK);
    read_flag = 1'b0;
    k = 0;
    while ((ack_total - base) < 2 && k < 100) begin
      @(negedge CLK);
      k++;
    end
    check("rstfill_two_acks", 32'(ack_total - base), 32'd2);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("rstfill_mem_req", mem_req, 0);
    check("rstfill_busy", busy, 0);
    check("rstfill_done", done, 0);
    check("rstfill_mem_addr", mem_addr, 32'h0);
    stray_cnt++;
    repeat (3) @(negedge CLK);
    check("stray_busy", busy, 0);
    check("stray_done", done, 0);
    check("stray_mem_req", mem_req, 0);
    check("stray_data", read_data, 32'h0);
    $display("reset mid-refill at 0x300, stray ack sent");

    // Line left invalid by the aborted refill
    do_read(32'h304, 1, 32'h300, 32'hC0DE0304, 0, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
